// File: rtl/pulpino_reset_seq.sv
// Reset and boot sequencer for the PULPino Qsys system. It merges PLL lock and the JTAG
// reset request into one clean system reset, then releases fetch enable a fixed delay later.
module pulpino_reset_seq #(
   parameter int LOCK_FILTER = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int FETCH_DELAY = 8,
   parameter int CNT_W       = 16
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       pll_locked,
   input  logic       jtag_reset,
   output logic       sys_reset_n,
   output logic       fetch_enable,
   output logic [1:0] seq_state,
   output logic [7:0] rst_events
);

   typedef enum logic [1:0] {
      WAIT_LOCK  = 2'd0,
      HOLD       = 2'd1,
      FETCH_WAIT = 2'd2,
      RUN        = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(FETCH_DELAY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             jtag_abort;
   logic [1:0]       lock_sync;
   logic [1:0]       jtag_sync;
   logic             locked_s;
   logic             jtag_s;

   // Both request inputs are asynchronous to CLK and pass through two flops each.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         lock_sync <= 2'b00;
         jtag_sync <= 2'b00;
      end else begin
         lock_sync <= {lock_sync[0], pll_locked};
         jtag_sync <= {jtag_sync[0], jtag_reset};
      end
   end

   assign locked_s = lock_sync[1];
   assign jtag_s   = jtag_sync[1];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= WAIT_LOCK;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Lock loss is checked before the JTAG request so it always wins.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      jtag_abort = 1'b0;
      case (state)
         WAIT_LOCK: begin
            if (!locked_s) begin
               cnt_nxt = '0;
            end else if (cnt == LOCK_LAST) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         HOLD: begin
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (jtag_s) begin
               cnt_nxt = '0;
            end else if (cnt == HOLD_LAST) begin
               state_nxt = FETCH_WAIT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         FETCH_WAIT: begin
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (jtag_s) begin
               state_nxt  = HOLD;
               cnt_nxt    = '0;
               jtag_abort = 1'b1;
            end else if (cnt == FETCH_LAST) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (jtag_s) begin
               state_nxt  = HOLD;
               cnt_nxt    = '0;
               jtag_abort = 1'b1;
            end
         end
         default: begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sys_reset_n  <= 1'b0;
         fetch_enable <= 1'b0;
         rst_events   <= 8'd0;
      end else begin
         sys_reset_n  <= (state_nxt == FETCH_WAIT) || (state_nxt == RUN);
         fetch_enable <= (state_nxt == RUN);
         if (jtag_abort && (rst_events != 8'hFF)) begin
            rst_events <= rst_events + 8'd1;
         end
      end
   end

   assign seq_state = state;

endmodule
